ram_arbiter: RTL and testbench

//  Shares one single-port data RAM between the CPU MEM-stage port and a DMA/loader master.

---
 rtl/ram_arb_pkg.sv | 26 ++
 rtl/arb_rr2.sv | 19 +
 rtl/ram_arbiter.sv | 140 ++++++++++++++
 tb/tb_ram_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the data-RAM arbiter.
// State encoding, owner ids, request bundle and the RD_LAT legality check live here.
package ram_arb_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: a lone requester wins, on contention the one
// that did not win last time wins.
module arb_rr2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_vld,
    output logic       gnt_id
);

    always_comb begin
        gnt_vld = |req;
        gnt_id  = OWN_CPU;
        if (req[OWN_DMA] && (!req[OWN_CPU] || last_gnt == OWN_CPU))
            gnt_id = OWN_DMA;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port data RAM between the CPU MEM stage and a DMA master.
// Optional perf counters are built when RAM_ARB_PERF_EN is defined.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [31:0]       dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    output logic [31:0]       dma_rdata,
    output logic              dma_rvalid,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [15:0]       perf_stall,
    output logic [15:0]       perf_dma
);

    localparam bit         RD_LAT_OK = rd_lat_legal(RD_LAT);
    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    if (!RD_LAT_OK) begin : g_bad_rd_lat
        $error("ram_arbiter: RD_LAT must be 1..4");
    end

    logic [1:0] state;
    logic       last_gnt;   // doubles as the owner of the access in flight
    logic [1:0] wait_cnt;
    logic       gnt_vld;
    logic       gnt_id;
    mreq_t      cpu_rq;
    mreq_t      dma_rq;
    mreq_t      sel_rq;
    logic       done_cycle;

    assign cpu_rq = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    assign dma_rq = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};
    assign sel_rq = (gnt_id == OWN_DMA) ? dma_rq : cpu_rq;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{sel_rq.addr[1:0], sel_rq.addr[31:ADDR_W+2]};

    arb_rr2 u_arb (
        .req      ({dma_req, cpu_ce}),
        .last_gnt (last_gnt),
        .gnt_vld  (gnt_vld),
        .gnt_id   (gnt_id)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            last_gnt  <= OWN_DMA;
            wait_cnt  <= '0;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_ce <= 1'b0;
            ram_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (gnt_vld) begin
                        state     <= S_ACCESS;
                        last_gnt  <= gnt_id;
                        ram_ce    <= 1'b1;
                        ram_we    <= sel_rq.we;
                        ram_addr  <= sel_rq.addr[ADDR_W+1:2];
                        ram_wdata <= sel_rq.wdata;
                    end
                end
                S_ACCESS: begin
                    if (ram_we)
                        state <= S_IDLE;
                    else if (RD_LAT == 1)
                        state <= S_RESP;
                    else begin
                        state    <= S_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt <= 2'd1)
                        state <= S_RESP;
                    else
                        wait_cnt <= wait_cnt - 2'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ram_we is only high during ACCESS, so it marks a finishing write there
    assign done_cycle = (state == S_ACCESS && ram_we) || (state == S_RESP);
    assign cpu_stall  = cpu_ce && !(last_gnt == OWN_CPU && done_cycle);
    assign cpu_rdata  = (cpu_ce && !cpu_we && last_gnt == OWN_CPU && state == S_RESP)
                        ? ram_rdata : '0;
    assign dma_gnt    = (state == S_ACCESS) && (last_gnt == OWN_DMA);
    assign dma_rvalid = (state == S_RESP) && (last_gnt == OWN_DMA);
    assign dma_rdata  = dma_rvalid ? ram_rdata : '0;

`ifdef RAM_ARB_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] dma_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            dma_cnt   <= '0;
        end else begin
            if (cpu_stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (dma_gnt && dma_cnt != 16'hFFFF)
                dma_cnt <= dma_cnt + 16'd1;
        end
    end

    assign perf_stall = stall_cnt;
    assign perf_dma   = dma_cnt;
`else
    assign perf_stall = '0;
    assign perf_dma   = '0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: two arbiters (RD_LAT=1 and RD_LAT=3) on shared stimulus,
// each with a behavioural RAM of matching read latency.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_ce = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;

    logic [31:0] cpu_rdata1, ram_wdata1, ram_rdata1, unused_dma_rdata1;
    logic        cpu_stall1, dma_gnt1, unused_dma_rvalid1, ram_ce1, ram_we1;
    logic [9:0]  ram_addr1;
    logic [15:0] perf_stall1, perf_dma1;

    logic [31:0] cpu_rdata3, ram_wdata3, ram_rdata3, dma_rdata3;
    logic        cpu_stall3, dma_gnt3, dma_rvalid3, ram_ce3, ram_we3;
    logic [9:0]  ram_addr3;
    logic [15:0] unused_perf_stall3, unused_perf_dma3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(10), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_ce(cpu_ce), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata1), .cpu_stall(cpu_stall1),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt1), .dma_rdata(unused_dma_rdata1), .dma_rvalid(unused_dma_rvalid1),
        .ram_ce(ram_ce1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
        .ram_rdata(ram_rdata1), .perf_stall(perf_stall1), .perf_dma(perf_dma1)
    );

    ram_arbiter #(.ADDR_W(10), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .cpu_ce(cpu_ce), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata3), .cpu_stall(cpu_stall3),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt3), .dma_rdata(dma_rdata3), .dma_rvalid(dma_rvalid3),
        .ram_ce(ram_ce3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
        .ram_rdata(ram_rdata3), .perf_stall(unused_perf_stall3), .perf_dma(unused_perf_dma3)
    );

    // RAM models: read port samples every cycle, data emerges RD_LAT cycles later
    logic [31:0] mem1 [1024];
    logic [31:0] mem3 [1024];
    logic [31:0] p3 [3];

    always @(posedge clk) begin
        if (ram_ce1 && ram_we1) mem1[ram_addr1] <= ram_wdata1;
        ram_rdata1 <= mem1[ram_addr1];
        if (ram_ce3 && ram_we3) mem3[ram_addr3] <= ram_wdata3;
        p3[0] <= mem3[ram_addr3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign ram_rdata3 = p3[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nxt();
        rst = 1'b0;
        cpu_ce = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        repeat (2) nxt();
        rst = 1'b1;
    endtask

    initial begin
        // reset state
        repeat (2) nxt();
        #1;
        chk("rst_ram_ce", ram_ce1, 0);
        chk("rst_ram_we", ram_we1, 0);
        chk("rst_ram_addr", ram_addr1, 0);
        chk("rst_stall", cpu_stall1, 0);
        chk("rst_gnt", dma_gnt1, 0);
        chk("rst_perf_stall", perf_stall1, 0);
        chk("rst_rvalid3", dma_rvalid3, 0);
        rst = 1'b1;

        // test 1: CPU write, one stall cycle
        nxt();
        cpu_ce = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hA5A5A5A5; #1;
        chk("t1_stall_idle", cpu_stall1, 1);
        chk("t1_ce_idle", ram_ce1, 0);
        nxt(); #1;
        chk("t1_stall_acc", cpu_stall1, 0);
        chk("t1_ram_ce", ram_ce1, 1);
        chk("t1_ram_we", ram_we1, 1);
        chk("t1_ram_addr", ram_addr1, 4);
        chk("t1_ram_wdata", ram_wdata1, 32'hA5A5A5A5);

        // test 2: CPU read back, two stall cycles
        nxt();
        cpu_we = 0; #1;
        chk("t2_ce_off", ram_ce1, 0);
        chk("t2_we_off", ram_we1, 0);
        chk("t2_stall0", cpu_stall1, 1);
        nxt(); #1;
        chk("t2_stall1", cpu_stall1, 1);
        chk("t2_ram_ce", ram_ce1, 1);
        chk("t2_ram_we", ram_we1, 0);
        nxt(); #1;
        chk("t2_stall_resp", cpu_stall1, 0);
        chk("t2_rdata", cpu_rdata1, 32'hA5A5A5A5);
        nxt();
        cpu_ce = 0; #1;
        chk("t2_idle_stall", cpu_stall1, 0);
        chk("t2_idle_rdata", cpu_rdata1, 0);
`ifdef RAM_ARB_PERF_EN
        chk("t2_perf_stall", perf_stall1, 3);
`else
        chk("t2_perf_stall", perf_stall1, 0);
`endif
        chk("t2_perf_dma", perf_dma1, 0);

        // test 3: contention after reset, CPU first then alternating
        do_reset();
        cpu_ce = 1; cpu_we = 0; cpu_addr = 32'h10;
        dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'hDEADBEEF; #1;
        chk("t3_stall0", cpu_stall1, 1);
        nxt(); #1;
        chk("t3_cpu_first_gnt", dma_gnt1, 0);
        chk("t3_cpu_addr", ram_addr1, 4);
        chk("t3_stall1", cpu_stall1, 1);
        nxt(); #1;
        chk("t3_rdata", cpu_rdata1, 32'hA5A5A5A5);
        chk("t3_stall_resp", cpu_stall1, 0);
        nxt();
        cpu_addr = 32'h40; #1;
        chk("t3_idle_gnt", dma_gnt1, 0);
        nxt(); #1;
        chk("t3_dma_gnt", dma_gnt1, 1);
        chk("t3_dma_we", ram_we1, 1);
        chk("t3_dma_addr", ram_addr1, 16);
        chk("t3_dma_wdata", ram_wdata1, 32'hDEADBEEF);
        chk("t3_stall_dma", cpu_stall1, 1);
        dma_addr = 32'h44; dma_wdata = 32'h01234567;
        nxt(); #1;
        chk("t3_idle2_gnt", dma_gnt1, 0);
        nxt(); #1;
        chk("t3_cpu2_gnt", dma_gnt1, 0);
        chk("t3_cpu2_addr", ram_addr1, 16);
        nxt(); #1;
        chk("t3_rdata2", cpu_rdata1, 32'hDEADBEEF);
        nxt();
        cpu_ce = 0; #1;
        chk("t3_idle3_gnt", dma_gnt1, 0);
        nxt(); #1;
        chk("t3_dma2_gnt", dma_gnt1, 1);
        chk("t3_dma2_addr", ram_addr1, 17);
        dma_req = 0;
        nxt(); #1;
`ifdef RAM_ARB_PERF_EN
        chk("t3_perf_stall", perf_stall1, 6);
        chk("t3_perf_dma", perf_dma1, 2);
`else
        chk("t3_perf_stall", perf_stall1, 0);
        chk("t3_perf_dma", perf_dma1, 0);
`endif

        // DMA request withdrawn before it ever sees IDLE: no access issued
        cpu_ce = 1; cpu_we = 0; cpu_addr = 32'h44;
        nxt();
        dma_req = 1; dma_we = 0; dma_addr = 32'h0; #1;
        chk("dd_gnt_acc", dma_gnt1, 0);
        nxt(); #1;
        chk("dd_rdata", cpu_rdata1, 32'h01234567);
        dma_req = 0;
        nxt();
        cpu_ce = 0; #1;
        chk("dd_idle_stall", cpu_stall1, 0);
        nxt(); #1;
        chk("dd_no_ce", ram_ce1, 0);
        chk("dd_no_gnt", dma_gnt1, 0);

        // test 4 (RD_LAT=3): DMA write then read of 0x20
        do_reset();
        dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h12345678;
        nxt(); #1;
        chk("t4_wr_gnt", dma_gnt3, 1);
        chk("t4_wr_addr", ram_addr3, 8);
        dma_req = 0;
        nxt();
        dma_req = 1; dma_we = 0; #1;
        chk("t4_idle_gnt", dma_gnt3, 0);
        nxt(); #1;
        chk("t4_rd_gnt", dma_gnt3, 1);
        chk("t4_rd_ce", ram_ce3, 1);
        dma_req = 0;
        nxt(); #1;
        chk("t4_rv_w1", dma_rvalid3, 0);
        chk("t4_gnt_pulse", dma_gnt3, 0);
        nxt(); #1;
        chk("t4_rv_w2", dma_rvalid3, 0);
        nxt(); #1;
        chk("t4_rvalid", dma_rvalid3, 1);
        chk("t4_rdata", dma_rdata3, 32'h12345678);
        nxt(); #1;
        chk("t4_rv_off", dma_rvalid3, 0);
        chk("t4_rdata_off", dma_rdata3, 0);

        // test 5 (RD_LAT=3): reset during WAIT abandons the DMA read
        dma_req = 1; dma_we = 0; dma_addr = 32'h20;
        nxt(); #1;
        chk("t5_gnt", dma_gnt3, 1);
        dma_req = 0;
        nxt();
        rst = 1'b0; #1;
        chk("t5_rst_ce", ram_ce3, 0);
        chk("t5_rst_rv", dma_rvalid3, 0);
        nxt(); #1;
        chk("t5_rst_rv1", dma_rvalid3, 0);
        nxt(); #1;
        chk("t5_rst_rv2", dma_rvalid3, 0);
        nxt();
        rst = 1'b1;
        cpu_ce = 1; cpu_we = 0; cpu_addr = 32'h20;
        dma_req = 1; dma_we = 1; dma_addr = 32'h24; dma_wdata = 32'h55; #1;
        chk("t5_stall_idle", cpu_stall3, 1);
        nxt(); #1;
        chk("t5_cpu_first", dma_gnt3, 0);
        chk("t5_cpu_addr", ram_addr3, 8);
        chk("t5_stall_acc", cpu_stall3, 1);
        nxt(); #1;
        chk("t5_stall_w1", cpu_stall3, 1);
        nxt(); #1;
        chk("t5_stall_w2", cpu_stall3, 1);
        nxt(); #1;
        chk("t5_stall_resp", cpu_stall3, 0);
        chk("t5_rdata", cpu_rdata3, 32'h12345678);
        nxt();
        cpu_ce = 0; #1;
        chk("t5_idle_gnt", dma_gnt3, 0);
        nxt(); #1;
        chk("t5_dma_gnt", dma_gnt3, 1);
        chk("t5_dma_addr", ram_addr3, 9);
        dma_req = 0;

        // async reset drops RAM strobes mid-ACCESS
        do_reset();
        cpu_ce = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'h7;
        nxt(); #1;
        chk("ar_ce_before", ram_ce1, 1);
        rst = 1'b0; #1;
        chk("ar_ce_now", ram_ce1, 0);
        chk("ar_we_now", ram_we1, 0);
        cpu_ce = 0;
        nxt();
        rst = 1'b1;
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
